// File: rtl/bytecode_mem_arbiter_if.sv
// Bundle of the fetch, loader and bytecode-RAM signals around the memory arbiter.
// Handshake: a requester holds req (and its address/data) until it sees gnt=1 in the same cycle.
// That cycle consumes the request. Read data returns later on the requester's rvalid and has no backpressure.
interface bytecode_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic [DATA_W-1:0] f_rdata;
  logic              f_rvalid;

  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic [DATA_W-1:0] l_rdata;
  logic              l_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbitration state for checkers: 0 = fetch was last granted, 1 = loader.
  logic              dbg_last_owner;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rdata, f_rvalid, l_gnt, l_rdata, l_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_last_owner
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rdata, f_rvalid, l_gnt, l_rdata, l_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata, dbg_last_owner
  );
endinterface

// File: rtl/bytecode_mem_arbiter.sv
// Round-robin arbiter sharing the single-port bytecode RAM between fetch and loader.
// It has a loader bus lock and a fixed-latency read-return pipeline.
module bytecode_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bytecode_mem_arbiter_if.slave bus
);

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_t;

  owner_t              r_last_owner;
  owner_t              w_next_owner;
  logic                w_f_gnt;
  logic                w_l_gnt;
  logic                w_rd;
  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [RD_LAT-1:0]   r_pipe_own;
  logic                w_out_vld;
  logic                w_out_own;

  // Grants are gated by rst so nothing reaches the RAM while reset is held.
  always_comb begin
    w_f_gnt      = 1'b0;
    w_l_gnt      = 1'b0;
    w_next_owner = r_last_owner;
    if (!rst) begin
      if (bus.l_lock) begin
        w_l_gnt = bus.l_req;
      end else if (bus.f_req && bus.l_req) begin
        if (r_last_owner == OWN_LOADER) w_f_gnt = 1'b1;
        else                            w_l_gnt = 1'b1;
      end else begin
        w_f_gnt = bus.f_req;
        w_l_gnt = bus.l_req;
      end
    end
    if (w_f_gnt)      w_next_owner = OWN_FETCH;
    else if (w_l_gnt) w_next_owner = OWN_LOADER;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last_owner <= OWN_LOADER;
    else     r_last_owner <= w_next_owner;
  end

  assign w_rd = w_f_gnt | (w_l_gnt & ~bus.l_we);

  // Stage 0 captures the read issued this cycle; the last stage lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_own <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd;
      r_pipe_own[0] <= w_l_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_own[i] <= r_pipe_own[i-1];
      end
    end
  end

  assign w_out_vld = r_pipe_vld[RD_LAT-1];
  assign w_out_own = r_pipe_own[RD_LAT-1];

  assign bus.f_gnt          = w_f_gnt;
  assign bus.l_gnt          = w_l_gnt;
  assign bus.mem_en         = w_f_gnt | w_l_gnt;
  assign bus.mem_we         = w_l_gnt & bus.l_we;
  assign bus.mem_addr       = w_l_gnt ? bus.l_addr : bus.f_addr;
  assign bus.mem_wdata      = (w_l_gnt & bus.l_we) ? bus.l_wdata : '0;
  assign bus.f_rvalid       = w_out_vld & ~w_out_own;
  assign bus.l_rvalid       = w_out_vld & w_out_own;
  assign bus.f_rdata        = (w_out_vld & ~w_out_own) ? bus.mem_rdata : '0;
  assign bus.l_rdata        = (w_out_vld & w_out_own) ? bus.mem_rdata : '0;
  assign bus.dbg_last_owner = r_last_owner;

endmodule

// File: tb/tb_bytecode_mem_arbiter.sv
// Bench for bytecode_mem_arbiter: three instances (RD_LAT 1, 3, 4) share one stimulus stream.
// Each instance is compared against a queue-based reference model of grants, RAM contents and read returns.
module tb_bytecode_mem_arbiter;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [11:0] f_addr;
  logic        l_req;
  logic        l_we;
  logic        l_lock;
  logic [11:0] l_addr;
  logic [7:0]  l_wdata;

  logic        o_fg [NI];
  logic        o_lg [NI];
  logic        o_en [NI];
  logic        o_we [NI];
  logic [11:0] o_addr [NI];
  logic [7:0]  o_wd [NI];
  logic        o_fv [NI];
  logic        o_lv [NI];
  logic [7:0]  o_fd [NI];
  logic [7:0]  o_ld [NI];
  logic        o_dbg [NI];

  int lats [NI] = '{1, 3, 4};

  function automatic logic [7:0] pat(int a);
    return 8'((a * 7 + 3) ^ (a >> 4));
  endfunction

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and RAM models ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;

    bytecode_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bif ();

    bytecode_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
    );

    assign bif.f_req   = f_req;
    assign bif.f_addr  = f_addr;
    assign bif.l_req   = l_req;
    assign bif.l_we    = l_we;
    assign bif.l_lock  = l_lock;
    assign bif.l_addr  = l_addr;
    assign bif.l_wdata = l_wdata;

    logic [7:0] ram [int];
    logic [7:0] rpipe [LAT];

    always @(posedge clk) begin
      if (bif.mem_en && bif.mem_we) ram[int'(bif.mem_addr)] = bif.mem_wdata;
      if (bif.mem_en && !bif.mem_we)
        rpipe[0] <= ram.exists(int'(bif.mem_addr)) ? ram[int'(bif.mem_addr)] : pat(int'(bif.mem_addr));
      else
        rpipe[0] <= 8'h00;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bif.mem_rdata = rpipe[LAT-1];

    assign o_fg[g]   = bif.f_gnt;
    assign o_lg[g]   = bif.l_gnt;
    assign o_en[g]   = bif.mem_en;
    assign o_we[g]   = bif.mem_we;
    assign o_addr[g] = bif.mem_addr;
    assign o_wd[g]   = bif.mem_wdata;
    assign o_fv[g]   = bif.f_rvalid;
    assign o_lv[g]   = bif.l_rvalid;
    assign o_fd[g]   = bif.f_rdata;
    assign o_ld[g]   = bif.l_rdata;
    assign o_dbg[g]  = bif.dbg_last_owner;
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    int         due;
    logic       own;   // 1 = loader
    logic [7:0] d;
  } ev_t;

  ev_t        exp_q [NI][$];
  logic [7:0] ref_mem [int];
  logic       ref_last_ldr;
  int         cyc;
  int         n_vec;
  int         n_err;

  function automatic logic [7:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s lat%0d cyc=%0d observed=%0h expected=%0h", tag, lats[g], cyc, obs, exp);
    end
  endtask

  // One clock: predict grants from the rules, check at negedge, then advance the model.
  task automatic cycle();
    logic eg_f, eg_l;
    eg_f = 1'b0;
    eg_l = 1'b0;
    if (rst) begin
      for (int g = 0; g < NI; g++) exp_q[g].delete();
      ref_last_ldr = 1'b1;
    end else if (l_lock) begin
      eg_l = l_req;
    end else if (f_req && l_req) begin
      eg_f = ref_last_ldr;
      eg_l = !ref_last_ldr;
    end else begin
      eg_f = f_req;
      eg_l = l_req;
    end

    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      logic       ev, eo;
      logic [7:0] ed;
      ev = 1'b0; eo = 1'b0; ed = 8'h00;
      if (exp_q[g].size() > 0 && exp_q[g][0].due == cyc) begin
        ev = 1'b1; eo = exp_q[g][0].own; ed = exp_q[g][0].d;
        void'(exp_q[g].pop_front());
      end
      chk("f_gnt",     g, 32'(o_fg[g]), 32'(eg_f));
      chk("l_gnt",     g, 32'(o_lg[g]), 32'(eg_l));
      chk("mem_en",    g, 32'(o_en[g]), 32'(eg_f | eg_l));
      chk("mem_we",    g, 32'(o_we[g]), 32'(eg_l & l_we));
      if (eg_f || eg_l)
        chk("mem_addr", g, 32'(o_addr[g]), 32'(eg_l ? l_addr : f_addr));
      chk("mem_wdata", g, 32'(o_wd[g]), 32'((eg_l && l_we) ? l_wdata : 8'h00));
      chk("f_rvalid",  g, 32'(o_fv[g]), 32'(ev && !eo));
      chk("l_rvalid",  g, 32'(o_lv[g]), 32'(ev && eo));
      chk("f_rdata",   g, 32'(o_fd[g]), 32'((ev && !eo) ? ed : 8'h00));
      chk("l_rdata",   g, 32'(o_ld[g]), 32'((ev && eo) ? ed : 8'h00));
    end

    if (eg_f || eg_l) begin
      ref_last_ldr = eg_l;
      if (eg_l && l_we) begin
        ref_mem[int'(l_addr)] = l_wdata;
      end else begin
        for (int g = 0; g < NI; g++)
          exp_q[g].push_back('{due: cyc + lats[g], own: eg_l,
                               d: ref_rd(int'(eg_l ? l_addr : f_addr))});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic f, logic [11:0] fa, logic l, logic we, logic lk,
                       logic [11:0] la, logic [7:0] wd);
    f_req = f; f_addr = fa; l_req = l; l_we = we; l_lock = lk; l_addr = la; l_wdata = wd;
    cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    cyc = 0; n_vec = 0; n_err = 0; ref_last_ldr = 1'b1;
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;

    // reset state: everything quiet while rst high
    do_reset(3);

    // sequential fetch reads 0..3
    for (int a = 0; a < 4; a++) drive(1'b1, 12'(a), 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    idle(5);

    // contention right after reset: F,L,F,L,F,L
    do_reset(1);
    for (int i = 0; i < 6; i++) drive(1'b1, 12'(12'h100 + i), 1'b1, 1'b0, 1'b0, 12'(12'h200 + i), 8'h00);
    idle(5);

    // loader write then fetch read-back of the same byte
    drive(1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h010, 8'hA7);
    drive(1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    idle(5);

    // lock blocks fetch for 5 cycles; fetch wins right after release
    for (int i = 0; i < 5; i++) drive(1'b1, 12'h020, 1'b1, 1'b0, 1'b1, 12'(12'h030 + i), 8'h00);
    drive(1'b1, 12'h020, 1'b1, 1'b0, 1'b0, 12'h035, 8'h00);
    idle(5);

    // reset with reads in flight: nothing may return afterwards
    drive(1'b1, 12'h040, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    drive(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h041, 8'h00);
    do_reset(2);
    idle(5);

    // top-of-memory addresses back-to-back
    drive(1'b1, 12'hFFE, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    drive(1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    idle(6);

    // randomized traffic, with occasional lock and rare resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset(1);
      drive(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), 12'($urandom_range(0, 4095)),
            8'($urandom_range(0, 255)));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
